muldiv_unit: RTL

//  Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, with HI/LO registers.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-decoding helpers for the iterative mul/div unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath on {acc, shreg}: shift-add multiply or restoring-divide step.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] trial;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        sum        = {1'b0, acc} + {1'b0, operand};
        rem        = {acc, shreg[WIDTH-1]};
        trial      = rem - {1'b0, operand};
        acc_next   = acc;
        shreg_next = shreg;
        if (is_div) begin
            // acc < divisor holds between steps, so the top bit of trial is a clean borrow flag.
            if (!trial[WIDTH]) begin
                acc_next   = trial[WIDTH-1:0];
                shreg_next = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = rem[WIDTH-1:0];
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shreg[0]) begin
                acc_next   = sum[WIDTH:1];
                shreg_next = {sum[0], shreg[WIDTH-1:1]};
            end else begin
                acc_next   = {1'b0, acc[WIDTH-1:1]};
                shreg_next = {acc[0], shreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one step per clock, WIDTH+2 edges per op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int               CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_e           state;
    op_e              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, shreg, operand, dividend;
    logic             neg_res, neg_rem, div_zero;

    op_e              op_in;
    logic             sgn_in;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] acc_next, shreg_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_in  = op_e'(i_op);
    assign sgn_in = is_signed_op(op_in);
    assign mag1   = (sgn_in && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
    assign mag2   = (sgn_in && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

    assign prod_fix = neg_res ? -{acc, shreg} : {acc, shreg};
    assign quo_fix  = neg_res ? -shreg : shreg;
    assign rem_fix  = neg_rem ? -acc : acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div_op(op_q)),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            op_q          <= OP_MULT;
            cnt           <= '0;
            acc           <= '0;
            shreg         <= '0;
            operand       <= '0;
            dividend      <= '0;
            neg_res       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_hi          <= '0;
            o_lo          <= '0;
        end else begin
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        op_q     <= op_in;
                        cnt      <= '0;
                        acc      <= '0;
                        shreg    <= mag1;
                        operand  <= mag2;
                        dividend <= i_op1;
                        neg_res  <= sgn_in && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                        neg_rem  <= sgn_in && i_op1[WIDTH-1];
                        div_zero <= (i_op2 == '0);
                        o_busy   <= 1'b1;
                        state    <= ST_RUN;
                    end else begin
                        if (i_mthi) o_hi <= i_op1;
                        if (i_mtlo) o_lo <= i_op1;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!is_div_op(op_q)) begin
                        {o_hi, o_lo} <= prod_fix;
                    end else if (div_zero) begin
                        o_hi <= dividend;
                        o_lo <= '1;
                    end else begin
                        o_hi <= rem_fix;
                        o_lo <= quo_fix;
                    end
                    o_div_by_zero <= is_div_op(op_q) && div_zero;
                    o_done        <= 1'b1;
                    o_busy        <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
